// File: rtl/dds_multichannel_core_pkg.sv
// Shared definitions for the multichannel DDS core: waveform modes, config
// register addresses and the reset duty value.
package dds_multichannel_core_pkg;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_PWM  = 2'd2,
        MODE_SAW  = 2'd3
    } dds_mode_e;

    localparam logic [1:0] ADDR_FREQ   = 2'd0;
    localparam logic [1:0] ADDR_OFFSET = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_MODE   = 2'd3;

    // Half of full scale (50% duty) for an accumulator of width w; callers truncate.
    function automatic logic [63:0] defaultDuty(int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM with symmetry folding; output is offset binary with
// phase 0 landing exactly on midscale.
module dds_sine_lut #(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic [LUT_AW+1:0] phase,
    output logic [OUT_W-1:0]  sample
);
    localparam int DEPTH = 1 << LUT_AW;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    typedef logic [OUT_W-2:0] rom_t [DEPTH];

    function automatic rom_t buildRom();
        rom_t r;
        real amp;
        amp = real'((1 << (OUT_W - 1)) - 1);
        for (int i = 0; i < DEPTH; i++) begin
            r[i] = (OUT_W-1)'($rtoi(amp * $sin(3.141592653589793 * real'(i) / (2.0 * real'(DEPTH))) + 0.5));
        end
        return r;
    endfunction

    localparam rom_t ROM = buildRom();

    logic [LUT_AW-1:0] idx;
    logic [OUT_W-2:0]  mag;

    // Second and fourth quarters read the table backwards; the upper half is negated.
    assign idx    = phase[LUT_AW] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];
    assign mag    = ROM[idx];
    assign sample = phase[LUT_AW+1] ? MID - {1'b0, mag} : MID + {1'b0, mag};

endmodule

// File: rtl/dds_multichannel_core.sv
// N-channel DDS engine with shadow/active config registers, a shared commit
// strobe for phase-coherent retunes and a two-stage sample pipeline.
module dds_multichannel_core
    import dds_multichannel_core_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int LUT_AW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_chan,
    input  logic [1:0]             cfg_addr,
    input  logic [PHASE_W-1:0]     cfg_data,
    output logic                   cfg_err,
    input  logic                   commit,
    input  logic                   sync_clear,
    output logic [NCH*OUT_W-1:0]   sample_out
);
    localparam logic [PHASE_W-1:0] DUTY_RST = PHASE_W'(defaultDuty(PHASE_W));

    logic accept;
    logic chanOk;

    // Writes are refused during a commit so shadow and active never race.
    assign cfg_ready = !commit;
    assign accept    = cfg_valid && cfg_ready;
    assign chanOk    = int'(cfg_chan) < NCH;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !chanOk;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : gChan
        logic [PHASE_W-1:0] freqS, offS, dutyS;
        logic [PHASE_W-1:0] freqA, offA, dutyA;
        dds_mode_e          modeS, modeA;
        logic [PHASE_W-1:0] acc, ph;
        logic [OUT_W-1:0]   sineVal, waveVal, sampleReg;
        logic               wrHere;

        assign wrHere = accept && chanOk && (cfg_chan == 3'(n));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                freqS     <= '0;
                offS      <= '0;
                dutyS     <= DUTY_RST;
                modeS     <= MODE_SINE;
                freqA     <= '0;
                offA      <= '0;
                dutyA     <= DUTY_RST;
                modeA     <= MODE_SINE;
                acc       <= '0;
                ph        <= '0;
                sampleReg <= '0;
            end else begin
                if (wrHere) begin
                    case (cfg_addr)
                        ADDR_FREQ:   freqS <= cfg_data;
                        ADDR_OFFSET: offS  <= cfg_data;
                        ADDR_DUTY:   dutyS <= cfg_data;
                        default:     modeS <= dds_mode_e'(cfg_data[1:0]);
                    endcase
                end
                if (commit) begin
                    freqA <= freqS;
                    offA  <= offS;
                    dutyA <= dutyS;
                    modeA <= modeS;
                end
                acc       <= sync_clear ? '0 : acc + freqA;
                ph        <= acc + offA;
                sampleReg <= waveVal;
            end
        end

        dds_sine_lut #(
            .LUT_AW (LUT_AW),
            .OUT_W  (OUT_W)
        ) uSineLut (
            .phase  (ph[PHASE_W-1 -: LUT_AW+2]),
            .sample (sineVal)
        );

        always_comb begin
            waveVal = '0;
            case (modeA)
                MODE_SINE: waveVal = sineVal;
                MODE_TRI:  waveVal = ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: OUT_W] : ph[PHASE_W-2 -: OUT_W];
                MODE_PWM:  waveVal = (ph < dutyA) ? '1 : '0;
                default:   waveVal = ph[PHASE_W-1 -: OUT_W];
            endcase
        end

        assign sample_out[n*OUT_W +: OUT_W] = sampleReg;
    end

endmodule

// File: tb/tb_dds_multichannel_core.sv
// Self-checking bench for dds_multichannel_core: randomized run against a
// behavioural model, a vector table and directed multi-cycle sequences.
module tb_dds_multichannel_core;
    localparam int NCH     = 2;
    localparam int PHASE_W = 32;
    localparam int OUT_W   = 16;
    localparam int LUT_AW  = 8;
    localparam int SINE_TOL = 450;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [2:0]           cfg_chan = '0;
    logic [1:0]           cfg_addr = '0;
    logic [PHASE_W-1:0]   cfg_data = '0;
    logic                 cfg_err;
    logic                 commit = 1'b0;
    logic                 sync_clear = 1'b0;
    logic [NCH*OUT_W-1:0] sample_out;

    int passCnt  = 0;
    int totalCnt = 0;

    dds_multichannel_core #(
        .NCH(NCH), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .commit(commit), .sync_clear(sync_clear),
        .sample_out(sample_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkNear(input string name, input logic [15:0] act, input int exp, input int tol);
        int d;
        totalCnt++;
        d = int'(act) - exp;
        if (d < 0) d = -d;
        if (d <= tol) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (+/-%0d)", name, act, exp, tol);
    endtask

    function automatic logic [15:0] chS(int n);
        return sample_out[n*OUT_W +: OUT_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input int ch, input int addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_chan  = 3'(ch);
        cfg_addr  = 2'(addr);
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic commitPulse(input bit sc);
        commit     = 1'b1;
        sync_clear = sc;
        tick();
        commit     = 1'b0;
        sync_clear = 1'b0;
    endtask

    // Expected waveform value straight from the mode definitions.
    function automatic int refWave(logic [31:0] ph, int mode, logic [31:0] duty);
        int u;
        case (mode)
            0: return int'(32768.0 + 32767.0 *
                           $sin(2.0 * 3.141592653589793 * real'(longint'(ph)) / 4294967296.0));
            1: begin
                u = int'((ph >> 15) & 32'hFFFF);
                return ph[31] ? 65535 - u : u;
            end
            2: return (ph < duty) ? 65535 : 0;
            default: return int'(ph >> 16);
        endcase
    endfunction

    // Behavioural model state
    logic [31:0] sFreq[NCH], sOff[NCH], sDuty[NCH];
    logic [31:0] aFreq[NCH], aOff[NCH], aDuty[NCH];
    int          sMode[NCH], aMode[NCH];
    logic [31:0] mAcc[NCH], mPh[NCH];
    int          mExp[NCH], mTol[NCH];
    bit          mErr;

    task automatic modelReset();
        for (int n = 0; n < NCH; n++) begin
            sFreq[n] = 0; sOff[n] = 0; sDuty[n] = 32'h8000_0000; sMode[n] = 0;
            aFreq[n] = 0; aOff[n] = 0; aDuty[n] = 32'h8000_0000; aMode[n] = 0;
            mAcc[n] = 0; mPh[n] = 0; mExp[n] = 0; mTol[n] = 0;
        end
        mErr = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        bit take;
        take = cfg_valid && !commit;
        for (int n = 0; n < NCH; n++) begin
            mExp[n] = refWave(mPh[n], aMode[n], aDuty[n]);
            mTol[n] = (aMode[n] == 0) ? SINE_TOL : 0;
            mPh[n]  = mAcc[n] + aOff[n];
            mAcc[n] = sync_clear ? 32'd0 : mAcc[n] + aFreq[n];
            if (commit) begin
                aFreq[n] = sFreq[n]; aOff[n] = sOff[n];
                aDuty[n] = sDuty[n]; aMode[n] = sMode[n];
            end
            if (take && int'(cfg_chan) == n) begin
                case (cfg_addr)
                    2'd0: sFreq[n] = cfg_data;
                    2'd1: sOff[n]  = cfg_data;
                    2'd2: sDuty[n] = cfg_data;
                    default: sMode[n] = int'(cfg_data[1:0]);
                endcase
            end
        end
        mErr = take && (int'(cfg_chan) >= NCH);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] freq;
        logic [31:0] off;
        logic [31:0] duty;
        int          k;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [31:0] accAt[64];

    initial begin
        int onesCnt;
        logic [15:0] e0;

        vecs[0]  = '{2'd3, 32'h4000_0000, 32'h0,          32'h8000_0000, 2,  16'h0000};
        vecs[1]  = '{2'd3, 32'h4000_0000, 32'h0,          32'h8000_0000, 3,  16'h4000};
        vecs[2]  = '{2'd3, 32'h4000_0000, 32'h0,          32'h8000_0000, 5,  16'hC000};
        vecs[3]  = '{2'd3, 32'h4000_0000, 32'h0,          32'h8000_0000, 6,  16'h0000};
        vecs[4]  = '{2'd3, 32'h1000_0000, 32'h0123_4567,  32'h8000_0000, 4,  16'h2123};
        vecs[5]  = '{2'd1, 32'h1000_0000, 32'h0,          32'h8000_0000, 4,  16'h4000};
        vecs[6]  = '{2'd1, 32'h1000_0000, 32'h0,          32'h8000_0000, 12, 16'hBFFF};
        vecs[7]  = '{2'd2, 32'h1000_0000, 32'h0,          32'h4000_0000, 5,  16'hFFFF};
        vecs[8]  = '{2'd2, 32'h1000_0000, 32'h0,          32'h4000_0000, 6,  16'h0000};
        vecs[9]  = '{2'd2, 32'h1000_0000, 32'h0,          32'h0,         2,  16'h0000};
        vecs[10] = '{2'd0, 32'h0,         32'h0,          32'h8000_0000, 3,  16'h8000};
        vecs[11] = '{2'd0, 32'h0,         32'h8000_0000,  32'h8000_0000, 2,  16'h8000};

        // Power-on reset, then randomized run against the model
        #3;
        check("reset sample_out", 64'(sample_out), 64'h0);
        check("reset cfg_ready", 64'(cfg_ready), 64'h1);
        check("reset cfg_err", 64'(cfg_err), 64'h0);
        tick();
        reset = 1'b0;
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < NCH; n++)
                checkNear($sformatf("rand c%0d ch%0d", cyc, n), chS(n), mExp[n], mTol[n]);
            check($sformatf("rand c%0d cfg_err", cyc), 64'(cfg_err), 64'(mErr));
            check($sformatf("rand c%0d cfg_ready", cyc), 64'(cfg_ready), 64'(!commit));
            cfg_valid  = ($urandom_range(0, 99) < 40);
            cfg_chan   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            cfg_addr   = 2'($urandom_range(0, 3));
            cfg_data   = $urandom;
            commit     = ($urandom_range(0, 99) < 10);
            sync_clear = ($urandom_range(0, 99) < 4);
            modelStep();
            tick();
        end
        cfg_valid = 1'b0; commit = 1'b0; sync_clear = 1'b0;

        // Reset mid-run, then idle channels settle to midscale
        #2 reset = 1'b1;
        #1;
        check("midrun reset sample_out", 64'(sample_out), 64'h0);
        check("midrun reset cfg_ready", 64'(cfg_ready), 64'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                check($sformatf("idle k%0d ch0", k), 64'(chS(0)), 64'h8000);
                check($sformatf("idle k%0d ch1", k), 64'(chS(1)), 64'h8000);
            end
        end

        // Sawtooth, then a shadow-only freq write followed by a later commit
        cfgWrite(0, 0, 32'h4000_0000);
        cfgWrite(0, 3, 32'd3);
        commitPulse(1'b0);
        accAt[0] = 32'h0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 10) begin
                cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_addr = 2'd0; cfg_data = 32'h2000_0000;
            end
            if (k == 11) cfg_valid = 1'b0;
            if (k == 14) commit = 1'b1;
            if (k == 15) commit = 1'b0;
            tick();
            accAt[k] = accAt[k-1] + ((k >= 15) ? 32'h2000_0000 : 32'h4000_0000);
            if (k >= 2) begin
                check($sformatf("saw k%0d ch0", k), 64'(chS(0)), 64'(accAt[k-2][31:16]));
                check($sformatf("saw k%0d ch1", k), 64'(chS(1)), 64'h8000);
            end
        end

        // Phase offset of half a cycle between two sawtooth channels
        cfgWrite(0, 0, 32'h1000_0000);
        cfgWrite(1, 0, 32'h1000_0000);
        cfgWrite(1, 1, 32'h8000_0000);
        cfgWrite(1, 3, 32'd3);
        commitPulse(1'b1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k >= 2) begin
                e0 = 16'((k - 2) * 32'h1000);
                check($sformatf("offset k%0d ch0", k), 64'(chS(0)), 64'(e0));
                check($sformatf("offset k%0d ch1", k), 64'(chS(1)), 64'(e0 ^ 16'h8000));
            end
        end

        // PWM at 25% duty, with an out-of-range write and a commit mid-stream
        cfgWrite(0, 3, 32'd2);
        cfgWrite(0, 2, 32'h4000_0000);
        commitPulse(1'b1);
        onesCnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 20) begin
                cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_addr = 2'd0; cfg_data = 32'hFFFF_FFFF;
            end
            if (k == 21) cfg_valid = 1'b0;
            if (k == 25) commit = 1'b1;
            if (k == 26) commit = 1'b0;
            tick();
            if (k >= 2) begin
                check($sformatf("pwm k%0d ch0", k), 64'(chS(0)),
                      (((k - 2) % 16) < 4) ? 64'hFFFF : 64'h0);
                check($sformatf("pwm k%0d ch1", k), 64'(chS(1)),
                      64'(16'((k - 2) * 32'h1000) ^ 16'h8000));
            end
            if (k >= 2 && k <= 17 && chS(0) == 16'hFFFF) onesCnt++;
            if (k >= 18 && k <= 23)
                check($sformatf("cfg_err k%0d", k), 64'(cfg_err), (k == 20) ? 64'h1 : 64'h0);
        end
        check("pwm high count per period", 64'(onesCnt), 64'd4);

        // Write presented during a commit waits one cycle
        commit = 1'b1; cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_addr = 2'd1; cfg_data = 32'h0;
        #1;
        check("handshake ready during commit", 64'(cfg_ready), 64'h0);
        tick();
        commit = 1'b0;
        #1;
        check("handshake ready after commit", 64'(cfg_ready), 64'h1);
        tick();
        cfg_valid = 1'b0;
        commitPulse(1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2)
                check($sformatf("handshake k%0d ch1", k), 64'(chS(1)), 64'(16'((k - 2) * 32'h1000)));
        end

        // Vector table on channel 0
        for (int i = 0; i < 12; i++) begin
            cfgWrite(0, 0, vecs[i].freq);
            cfgWrite(0, 1, vecs[i].off);
            cfgWrite(0, 2, vecs[i].duty);
            cfgWrite(0, 3, 32'(vecs[i].mode));
            commitPulse(1'b1);
            repeat (vecs[i].k) tick();
            check($sformatf("vec%0d ch0", i), 64'(chS(0)), 64'(vecs[i].exp));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
